// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl
// Pipeline controller for a 5-stage RV32I core. It carries the decoded D-stage
// control fields through the E/M/W stage registers and derives from them:
// stall and flush, PC redirect, forwarding and bypass selects, ALU operand
// selects, data-memory byte enables and write-back controls.
//
// Ports
//   clk, rst                        clock (rising edge), synchronous active-low reset
//   D_op/D_f3/D_f7                  D-stage opcode[6:2], funct3, funct7[5]
//   D_rd/D_rs1/D_rs2                D-stage register indices
//   b                               E-stage branch condition
//   stall, flush, next_pc_sel       front-end hold / discard / PC source (1 = PC+4)
//   D_rs1_data_sel, D_rs2_data_sel  1 = D register read takes W write-back data
//   E_rs1_data_sel, E_rs2_data_sel  0 = D-latched, 1 = M ALU result, 2 = W data
//   E_alu_op1_sel, E_alu_op2_sel    1 = PC / immediate
//   E_jb_op1_sel                    1 = PC as jump/branch base
//   E_op_out, E_f3_out, E_f7_out    E-stage fields for the ALU
//   M_dm_w_en                       data-memory byte write enables
//   W_wb_en, W_rd_index, W_f3       register-file write controls
//   W_wb_data_sel                   1 = load data, 0 = ALU result
module pipe_hazard_ctrl #(
  parameter int REG_IDX_W = 5,
  parameter bit FWD_EN    = 1'b1,
  parameter bit WB_BYPASS = 1'b1,
  parameter int DM_LANES  = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [4:0]           D_op,
  input  logic [2:0]           D_f3,
  input  logic                 D_f7,
  input  logic [REG_IDX_W-1:0] D_rd,
  input  logic [REG_IDX_W-1:0] D_rs1,
  input  logic [REG_IDX_W-1:0] D_rs2,
  input  logic                 b,
  output logic                 stall,
  output logic                 flush,
  output logic                 next_pc_sel,
  output logic                 D_rs1_data_sel,
  output logic                 D_rs2_data_sel,
  output logic [1:0]           E_rs1_data_sel,
  output logic [1:0]           E_rs2_data_sel,
  output logic                 E_alu_op1_sel,
  output logic                 E_alu_op2_sel,
  output logic                 E_jb_op1_sel,
  output logic [4:0]           E_op_out,
  output logic [2:0]           E_f3_out,
  output logic                 E_f7_out,
  output logic [DM_LANES-1:0]  M_dm_w_en,
  output logic                 W_wb_en,
  output logic [REG_IDX_W-1:0] W_rd_index,
  output logic [2:0]           W_f3,
  output logic                 W_wb_data_sel
);

  localparam logic [4:0] OP_R      = 5'b01100;
  localparam logic [4:0] OP_IMM    = 5'b00100;
  localparam logic [4:0] OP_LOAD   = 5'b00000;
  localparam logic [4:0] OP_JALR   = 5'b11001;
  localparam logic [4:0] OP_STORE  = 5'b01000;
  localparam logic [4:0] OP_BRANCH = 5'b11000;
  localparam logic [4:0] OP_LUI    = 5'b01101;
  localparam logic [4:0] OP_AUIPC  = 5'b00101;
  localparam logic [4:0] OP_JAL    = 5'b11011;

  function automatic logic f_known(input logic [4:0] op);
    case (op)
      OP_R, OP_IMM, OP_LOAD, OP_JALR, OP_STORE,
      OP_BRANCH, OP_LUI, OP_AUIPC, OP_JAL: f_known = 1'b1;
      default:                             f_known = 1'b0;
    endcase
  endfunction

  // Unknown opcodes never reach E, so they are not treated as source readers.
  function automatic logic f_uses_rs1(input logic [4:0] op);
    f_uses_rs1 = f_known(op) && (op != OP_LUI) && (op != OP_AUIPC) && (op != OP_JAL);
  endfunction

  function automatic logic f_uses_rs2(input logic [4:0] op);
    f_uses_rs2 = (op == OP_R) || (op == OP_STORE) || (op == OP_BRANCH);
  endfunction

  function automatic logic f_wr_class(input logic [4:0] op);
    f_wr_class = f_known(op) && (op != OP_STORE) && (op != OP_BRANCH);
  endfunction

  // M wins over W; a load in M has no result yet, so it falls through to W.
  function automatic logic [1:0] f_fwd(input logic [REG_IDX_W-1:0] s,
                                       input logic m_wr, input logic [REG_IDX_W-1:0] m_rd,
                                       input logic m_is_load,
                                       input logic w_wr, input logic [REG_IDX_W-1:0] w_rd);
    if (s == '0)                                  f_fwd = 2'd0;
    else if (m_wr && (m_rd == s) && !m_is_load)   f_fwd = 2'd1;
    else if (w_wr && (w_rd == s))                 f_fwd = 2'd2;
    else                                          f_fwd = 2'd0;
  endfunction

  logic                 r_e_valid, r_m_valid, r_w_valid;
  logic [4:0]           r_e_op, r_m_op, r_w_op;
  logic [2:0]           r_e_f3, r_m_f3, r_w_f3;
  logic                 r_e_f7;
  logic [REG_IDX_W-1:0] r_e_rd, r_m_rd, r_w_rd;
  logic [REG_IDX_W-1:0] r_e_rs1, r_e_rs2;

  logic w_d_use1, w_d_use2;
  logic w_e_wr, w_m_wr, w_w_wr;
  logic w_e_hit, w_m_hit, w_w_hit;
  logic w_hazard, w_redirect, w_e_load;

  assign w_d_use1 = f_uses_rs1(D_op);
  assign w_d_use2 = f_uses_rs2(D_op);

  assign w_e_wr = r_e_valid && f_wr_class(r_e_op) && (r_e_rd != '0);
  assign w_m_wr = r_m_valid && f_wr_class(r_m_op) && (r_m_rd != '0);
  assign w_w_wr = r_w_valid && f_wr_class(r_w_op) && (r_w_rd != '0);

  assign w_e_hit = w_e_wr && ((w_d_use1 && (D_rs1 == r_e_rd)) || (w_d_use2 && (D_rs2 == r_e_rd)));
  assign w_m_hit = w_m_wr && ((w_d_use1 && (D_rs1 == r_m_rd)) || (w_d_use2 && (D_rs2 == r_m_rd)));
  assign w_w_hit = w_w_wr && ((w_d_use1 && (D_rs1 == r_w_rd)) || (w_d_use2 && (D_rs2 == r_w_rd)));

  assign w_hazard = (w_e_hit && (r_e_op == OP_LOAD))
                  || (!FWD_EN && (w_e_hit || w_m_hit))
                  || (!FWD_EN && !WB_BYPASS && w_w_hit);

  assign w_redirect = r_e_valid && ((r_e_op == OP_JAL) || (r_e_op == OP_JALR)
                                    || ((r_e_op == OP_BRANCH) && b));

  // A redirect discards the D instruction, so it masks any stall it would cause.
  assign flush       = w_redirect;
  assign next_pc_sel = !w_redirect;
  assign stall       = w_hazard && !w_redirect;
  assign w_e_load    = !w_redirect && !w_hazard && f_known(D_op);

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_e_valid <= 1'b0; r_e_op <= '0; r_e_f3 <= '0; r_e_f7 <= 1'b0;
      r_e_rd <= '0; r_e_rs1 <= '0; r_e_rs2 <= '0;
      r_m_valid <= 1'b0; r_m_op <= '0; r_m_f3 <= '0; r_m_rd <= '0;
      r_w_valid <= 1'b0; r_w_op <= '0; r_w_f3 <= '0; r_w_rd <= '0;
    end else begin
      if (w_e_load) begin
        r_e_valid <= 1'b1; r_e_op <= D_op; r_e_f3 <= D_f3; r_e_f7 <= D_f7;
        r_e_rd <= D_rd; r_e_rs1 <= D_rs1; r_e_rs2 <= D_rs2;
      end else begin
        r_e_valid <= 1'b0; r_e_op <= '0; r_e_f3 <= '0; r_e_f7 <= 1'b0;
        r_e_rd <= '0; r_e_rs1 <= '0; r_e_rs2 <= '0;
      end
      r_m_valid <= r_e_valid; r_m_op <= r_e_op; r_m_f3 <= r_e_f3; r_m_rd <= r_e_rd;
      r_w_valid <= r_m_valid; r_w_op <= r_m_op; r_w_f3 <= r_m_f3; r_w_rd <= r_m_rd;
    end
  end

  assign E_rs1_data_sel = FWD_EN ? f_fwd(r_e_rs1, w_m_wr, r_m_rd, (r_m_op == OP_LOAD), w_w_wr, r_w_rd) : 2'd0;
  assign E_rs2_data_sel = FWD_EN ? f_fwd(r_e_rs2, w_m_wr, r_m_rd, (r_m_op == OP_LOAD), w_w_wr, r_w_rd) : 2'd0;

  assign D_rs1_data_sel = WB_BYPASS && w_w_wr && (r_w_rd == D_rs1) && (D_rs1 != '0);
  assign D_rs2_data_sel = WB_BYPASS && w_w_wr && (r_w_rd == D_rs2) && (D_rs2 != '0);

  assign E_alu_op1_sel = r_e_valid && ((r_e_op == OP_AUIPC) || (r_e_op == OP_JAL) || (r_e_op == OP_JALR));
  assign E_alu_op2_sel = r_e_valid && ((r_e_op == OP_IMM) || (r_e_op == OP_LOAD) || (r_e_op == OP_STORE)
                                       || (r_e_op == OP_LUI) || (r_e_op == OP_AUIPC));
  assign E_jb_op1_sel  = r_e_valid && ((r_e_op == OP_JAL) || (r_e_op == OP_BRANCH));
  assign E_op_out      = r_e_op;
  assign E_f3_out      = r_e_f3;
  assign E_f7_out      = r_e_f7;

  always_comb begin
    M_dm_w_en = '0;
    if (r_m_valid && (r_m_op == OP_STORE)) begin
      case (r_m_f3)
        3'b000:  M_dm_w_en[0]   = 1'b1;
        3'b001:  M_dm_w_en[1:0] = 2'b11;
        3'b010:  M_dm_w_en[3:0] = 4'b1111;
        default: M_dm_w_en      = '0;
      endcase
    end
  end

  assign W_wb_en       = w_w_wr;
  assign W_wb_data_sel = r_w_valid && (r_w_op == OP_LOAD);
  assign W_rd_index    = r_w_rd;
  assign W_f3          = r_w_f3;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Bench for pipe_hazard_ctrl. Instance 0 uses forwarding and W bypass,
// instance 1 has both disabled. A reference model tracks which instruction
// sits in E, M and W and predicts every output from the instruction classes.
module tb_pipe_hazard_ctrl;

  localparam logic [4:0] OP_R     = 5'b01100;
  localparam logic [4:0] OP_I     = 5'b00100;
  localparam logic [4:0] OP_LD    = 5'b00000;
  localparam logic [4:0] OP_JALR  = 5'b11001;
  localparam logic [4:0] OP_ST    = 5'b01000;
  localparam logic [4:0] OP_BR    = 5'b11000;
  localparam logic [4:0] OP_LUI   = 5'b01101;
  localparam logic [4:0] OP_AUIPC = 5'b00101;
  localparam logic [4:0] OP_JAL   = 5'b11011;
  localparam logic [4:0] OP_BAD   = 5'b11111;

  typedef struct packed {
    logic       v;
    logic [4:0] op;
    logic [2:0] f3;
    logic       f7;
    logic [4:0] rd;
    logic [4:0] rs1;
    logic [4:0] rs2;
  } ins_t;

  typedef struct packed {
    logic       stall, flush, npc, d1, d2;
    logic [1:0] e1, e2;
    logic       op1, op2, jb;
    logic [4:0] eop;
    logic [2:0] ef3;
    logic       ef7;
    logic [3:0] dm;
    logic       wb;
    logic [4:0] wrd;
    logic [2:0] wf3;
    logic       wsel;
  } exp_t;

  logic clk;
  logic rst_n;
  ins_t d_in [2];
  logic b_in [2];

  logic       stall_o [2], flush_o [2], npc_o [2], d1_o [2], d2_o [2];
  logic [1:0] e1_o [2], e2_o [2];
  logic       op1_o [2], op2_o [2], jb_o [2];
  logic [4:0] eop_o [2];
  logic [2:0] ef3_o [2];
  logic       ef7_o [2];
  logic [3:0] dm_o [2];
  logic       wb_o [2];
  logic [4:0] wrd_o [2];
  logic [2:0] wf3_o [2];
  logic       wsel_o [2];

  int   n_err, n_chk;
  bit   started;
  bit   last_stall [2];
  ins_t pipe [2][3];

  pipe_hazard_ctrl #(.REG_IDX_W(5), .FWD_EN(1'b1), .WB_BYPASS(1'b1), .DM_LANES(4)) u_dut0 (
    .clk(clk), .rst(rst_n),
    .D_op(d_in[0].op), .D_f3(d_in[0].f3), .D_f7(d_in[0].f7),
    .D_rd(d_in[0].rd), .D_rs1(d_in[0].rs1), .D_rs2(d_in[0].rs2), .b(b_in[0]),
    .stall(stall_o[0]), .flush(flush_o[0]), .next_pc_sel(npc_o[0]),
    .D_rs1_data_sel(d1_o[0]), .D_rs2_data_sel(d2_o[0]),
    .E_rs1_data_sel(e1_o[0]), .E_rs2_data_sel(e2_o[0]),
    .E_alu_op1_sel(op1_o[0]), .E_alu_op2_sel(op2_o[0]), .E_jb_op1_sel(jb_o[0]),
    .E_op_out(eop_o[0]), .E_f3_out(ef3_o[0]), .E_f7_out(ef7_o[0]),
    .M_dm_w_en(dm_o[0]), .W_wb_en(wb_o[0]), .W_rd_index(wrd_o[0]),
    .W_f3(wf3_o[0]), .W_wb_data_sel(wsel_o[0])
  );

  pipe_hazard_ctrl #(.REG_IDX_W(5), .FWD_EN(1'b0), .WB_BYPASS(1'b0), .DM_LANES(4)) u_dut1 (
    .clk(clk), .rst(rst_n),
    .D_op(d_in[1].op), .D_f3(d_in[1].f3), .D_f7(d_in[1].f7),
    .D_rd(d_in[1].rd), .D_rs1(d_in[1].rs1), .D_rs2(d_in[1].rs2), .b(b_in[1]),
    .stall(stall_o[1]), .flush(flush_o[1]), .next_pc_sel(npc_o[1]),
    .D_rs1_data_sel(d1_o[1]), .D_rs2_data_sel(d2_o[1]),
    .E_rs1_data_sel(e1_o[1]), .E_rs2_data_sel(e2_o[1]),
    .E_alu_op1_sel(op1_o[1]), .E_alu_op2_sel(op2_o[1]), .E_jb_op1_sel(jb_o[1]),
    .E_op_out(eop_o[1]), .E_f3_out(ef3_o[1]), .E_f7_out(ef7_o[1]),
    .M_dm_w_en(dm_o[1]), .W_wb_en(wb_o[1]), .W_rd_index(wrd_o[1]),
    .W_f3(wf3_o[1]), .W_wb_data_sel(wsel_o[1])
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // ---------------- reference model ----------------
  function automatic bit known(input logic [4:0] op);
    return op inside {OP_R, OP_I, OP_LD, OP_JALR, OP_ST, OP_BR, OP_LUI, OP_AUIPC, OP_JAL};
  endfunction

  function automatic bit uses1(input logic [4:0] op);
    return op inside {OP_R, OP_I, OP_LD, OP_JALR, OP_ST, OP_BR};
  endfunction

  function automatic bit uses2(input logic [4:0] op);
    return op inside {OP_R, OP_ST, OP_BR};
  endfunction

  function automatic bit writes(input ins_t x);
    return x.v && (x.op inside {OP_R, OP_I, OP_LD, OP_JALR, OP_LUI, OP_AUIPC, OP_JAL}) && (x.rd != 0);
  endfunction

  function automatic bit reads_result_of(input ins_t producer, input ins_t d);
    return writes(producer) && ((uses1(d.op) && d.rs1 == producer.rd) || (uses2(d.op) && d.rs2 == producer.rd));
  endfunction

  function automatic logic [1:0] src_pick(input logic [4:0] s, input ins_t m, input ins_t w, input bit fwd);
    if (!fwd || s == 0) return 2'd0;
    if (writes(m) && m.rd == s && m.op != OP_LD) return 2'd1;
    if (writes(w) && w.rd == s) return 2'd2;
    return 2'd0;
  endfunction

  function automatic exp_t exp_out(input int k);
    exp_t r;
    ins_t e, m, w, d;
    bit fwd, byp, redirect, hazard;
    e = pipe[k][0]; m = pipe[k][1]; w = pipe[k][2]; d = d_in[k];
    fwd = (k == 0);
    byp = (k == 0);
    redirect = e.v && (e.op == OP_JAL || e.op == OP_JALR || (e.op == OP_BR && b_in[k]));
    hazard = (reads_result_of(e, d) && e.op == OP_LD)
          || (!fwd && (reads_result_of(e, d) || reads_result_of(m, d)))
          || (!fwd && !byp && reads_result_of(w, d));
    r = '0;
    r.flush = redirect;
    r.npc   = !redirect;
    r.stall = hazard && !redirect;
    r.d1    = byp && writes(w) && w.rd == d.rs1 && d.rs1 != 0;
    r.d2    = byp && writes(w) && w.rd == d.rs2 && d.rs2 != 0;
    r.e1    = src_pick(e.rs1, m, w, fwd);
    r.e2    = src_pick(e.rs2, m, w, fwd);
    r.op1   = e.v && (e.op inside {OP_AUIPC, OP_JAL, OP_JALR});
    r.op2   = e.v && (e.op inside {OP_I, OP_LD, OP_ST, OP_LUI, OP_AUIPC});
    r.jb    = e.v && (e.op inside {OP_JAL, OP_BR});
    r.eop   = e.op;
    r.ef3   = e.f3;
    r.ef7   = e.f7;
    if (m.v && m.op == OP_ST) begin
      case (m.f3)
        3'd0:    r.dm = 4'b0001;
        3'd1:    r.dm = 4'b0011;
        3'd2:    r.dm = 4'b1111;
        default: r.dm = 4'b0000;
      endcase
    end
    r.wb   = writes(w);
    r.wrd  = w.rd;
    r.wf3  = w.f3;
    r.wsel = w.v && w.op == OP_LD;
    return r;
  endfunction

  task automatic model_edge();
    for (int k = 0; k < 2; k++) begin
      exp_t e;
      ins_t nw;
      e = exp_out(k);
      if (!rst_n) begin
        for (int s = 0; s < 3; s++) pipe[k][s] = '0;
      end else begin
        nw = d_in[k];
        nw.v = 1'b1;
        if (e.stall || e.flush || !known(d_in[k].op)) nw = '0;
        pipe[k][2] = pipe[k][1];
        pipe[k][1] = pipe[k][0];
        pipe[k][0] = nw;
      end
    end
  endtask

  // ---------------- checking ----------------
  task automatic cmp(input string nm, input int k, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s dut%0d @%0t: got %0h expected %0h", nm, k, $time, act, exp);
    end
  endtask

  task automatic lit(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s @%0t: got %0h expected %0h", nm, $time, act, exp);
    end
  endtask

  task automatic check_all();
    for (int k = 0; k < 2; k++) begin
      exp_t e;
      e = exp_out(k);
      last_stall[k] = e.stall;
      cmp("stall", k, 32'(stall_o[k]), 32'(e.stall));
      cmp("flush", k, 32'(flush_o[k]), 32'(e.flush));
      cmp("next_pc_sel", k, 32'(npc_o[k]), 32'(e.npc));
      cmp("D_rs1_data_sel", k, 32'(d1_o[k]), 32'(e.d1));
      cmp("D_rs2_data_sel", k, 32'(d2_o[k]), 32'(e.d2));
      cmp("E_rs1_data_sel", k, 32'(e1_o[k]), 32'(e.e1));
      cmp("E_rs2_data_sel", k, 32'(e2_o[k]), 32'(e.e2));
      cmp("E_alu_op1_sel", k, 32'(op1_o[k]), 32'(e.op1));
      cmp("E_alu_op2_sel", k, 32'(op2_o[k]), 32'(e.op2));
      cmp("E_jb_op1_sel", k, 32'(jb_o[k]), 32'(e.jb));
      cmp("E_op_out", k, 32'(eop_o[k]), 32'(e.eop));
      cmp("E_f3_out", k, 32'(ef3_o[k]), 32'(e.ef3));
      cmp("E_f7_out", k, 32'(ef7_o[k]), 32'(e.ef7));
      cmp("M_dm_w_en", k, 32'(dm_o[k]), 32'(e.dm));
      cmp("W_wb_en", k, 32'(wb_o[k]), 32'(e.wb));
      cmp("W_rd_index", k, 32'(wrd_o[k]), 32'(e.wrd));
      cmp("W_f3", k, 32'(wf3_o[k]), 32'(e.wf3));
      cmp("W_wb_data_sel", k, 32'(wsel_o[k]), 32'(e.wsel));
    end
  endtask

  // Inputs are set just after a falling edge; outputs are checked before the rising edge.
  task automatic tick();
    #1;
    if (started) check_all();
    @(posedge clk);
    model_edge();
    if (!rst_n) started = 1'b1;
    @(negedge clk);
  endtask

  function automatic ins_t mk(input logic [4:0] op, input logic [2:0] f3, input logic f7,
                              input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2);
    ins_t x;
    x.v = 1'b1; x.op = op; x.f3 = f3; x.f7 = f7; x.rd = rd; x.rs1 = rs1; x.rs2 = rs2;
    return x;
  endfunction

  function automatic ins_t rnd_ins();
    ins_t x;
    int sel;
    sel = $urandom_range(0, 9);
    case (sel)
      0: x.op = OP_R;
      1: x.op = OP_I;
      2: x.op = OP_LD;
      3: x.op = OP_JALR;
      4: x.op = OP_ST;
      5: x.op = OP_BR;
      6: x.op = OP_LUI;
      7: x.op = OP_AUIPC;
      8: x.op = OP_JAL;
      default: x.op = 5'($urandom_range(0, 31));
    endcase
    x.v   = 1'b1;
    x.f3  = 3'($urandom_range(0, 7));
    x.f7  = 1'($urandom_range(0, 1));
    x.rd  = 5'($urandom_range(0, 3));
    x.rs1 = 5'($urandom_range(0, 3));
    x.rs2 = 5'($urandom_range(0, 3));
    return x;
  endfunction

  initial begin
    ins_t nop;
    n_err = 0;
    n_chk = 0;
    started = 1'b0;
    rst_n = 1'b0;
    nop = mk(OP_BAD, 3'd0, 1'b0, 5'd0, 5'd0, 5'd0);
    for (int k = 0; k < 2; k++) begin
      d_in[k] = nop;
      b_in[k] = 1'b0;
      last_stall[k] = 1'b0;
      for (int s = 0; s < 3; s++) pipe[k][s] = '0;
    end
    @(negedge clk);

    // reset held for two cycles with random D inputs
    for (int i = 0; i < 2; i++) begin
      d_in[0] = rnd_ins(); d_in[1] = rnd_ins();
      b_in[0] = 1'($urandom_range(0, 1)); b_in[1] = 1'($urandom_range(0, 1));
      if (i == 1) begin
        #1;
        lit("rst_next_pc_sel", 32'(npc_o[0]), 32'd1);
        lit("rst_stall", 32'(stall_o[0]), 32'd0);
        lit("rst_flush", 32'(flush_o[0]), 32'd0);
        lit("rst_wb_en", 32'(wb_o[0]), 32'd0);
        lit("rst_dm_w_en", 32'(dm_o[0]), 32'd0);
      end
      tick();
    end
    rst_n = 1'b1;
    b_in[0] = 1'b0; b_in[1] = 1'b0;
    d_in[1] = nop;

    // first add reaches W three edges after reset release
    d_in[0] = mk(OP_R, 3'd0, 1'b0, 5'd1, 5'd2, 5'd3); tick();
    d_in[0] = nop; tick(); tick();
    #1;
    lit("first_add_wb_en", 32'(wb_o[0]), 32'd1);
    lit("first_add_rd", 32'(wrd_o[0]), 32'd1);

    // load-use: lw x5 then add x6,x5,x7
    d_in[0] = mk(OP_LD, 3'b010, 1'b0, 5'd5, 5'd1, 5'd0); tick();
    d_in[0] = mk(OP_R, 3'd0, 1'b0, 5'd6, 5'd5, 5'd7);
    #1; lit("lu_stall_on", 32'(stall_o[0]), 32'd1);
    tick();
    #1; lit("lu_stall_off", 32'(stall_o[0]), 32'd0);
    lit("lu_e_bubble_op2", 32'(op2_o[0]), 32'd0);
    tick();
    d_in[0] = nop;
    #1;
    lit("lu_e_rs1_sel", 32'(e1_o[0]), 32'd2);
    lit("lu_e_rs2_sel", 32'(e2_o[0]), 32'd0);
    lit("lu_w_data_sel", 32'(wsel_o[0]), 32'd1);
    lit("lu_w_f3", 32'(wf3_o[0]), 32'd2);
    tick();

    // forward priority: M over W, x0 never forwards
    d_in[0] = mk(OP_I, 3'd0, 1'b0, 5'd3, 5'd1, 5'd0); tick();
    d_in[0] = mk(OP_I, 3'd0, 1'b0, 5'd3, 5'd2, 5'd0); tick();
    d_in[0] = mk(OP_R, 3'd0, 1'b0, 5'd4, 5'd3, 5'd3); tick();
    d_in[0] = nop;
    #1;
    lit("fwd_rs1_from_m", 32'(e1_o[0]), 32'd1);
    lit("fwd_rs2_from_m", 32'(e2_o[0]), 32'd1);
    tick();
    d_in[0] = mk(OP_I, 3'd0, 1'b0, 5'd0, 5'd1, 5'd0); tick();
    d_in[0] = mk(OP_R, 3'd0, 1'b0, 5'd8, 5'd0, 5'd0); tick();
    d_in[0] = nop;
    #1;
    lit("x0_rs1_sel", 32'(e1_o[0]), 32'd0);
    lit("x0_rs2_sel", 32'(e2_o[0]), 32'd0);
    tick();
    #1; lit("x0_wb_en", 32'(wb_o[0]), 32'd0);
    tick();

    // redirects
    d_in[0] = mk(OP_BR, 3'd0, 1'b0, 5'd0, 5'd1, 5'd2); tick();
    d_in[0] = mk(OP_R, 3'd0, 1'b0, 5'd9, 5'd1, 5'd2); b_in[0] = 1'b1;
    #1;
    lit("br_taken_npc", 32'(npc_o[0]), 32'd0);
    lit("br_taken_flush", 32'(flush_o[0]), 32'd1);
    lit("br_jb_op1", 32'(jb_o[0]), 32'd1);
    tick();
    b_in[0] = 1'b0; d_in[0] = nop;
    #1;
    lit("br_after_flush", 32'(flush_o[0]), 32'd0);
    lit("br_e_bubble_op", 32'(eop_o[0]), 32'd0);
    tick();
    d_in[0] = mk(OP_BR, 3'd1, 1'b0, 5'd0, 5'd1, 5'd2); tick();
    d_in[0] = nop;
    #1;
    lit("br_not_taken_flush", 32'(flush_o[0]), 32'd0);
    lit("br_not_taken_npc", 32'(npc_o[0]), 32'd1);
    tick();
    d_in[0] = mk(OP_JAL, 3'd0, 1'b0, 5'd1, 5'd0, 5'd0); tick();
    d_in[0] = nop;
    #1;
    lit("jal_flush", 32'(flush_o[0]), 32'd1);
    lit("jal_jb_op1", 32'(jb_o[0]), 32'd1);
    lit("jal_alu_op1", 32'(op1_o[0]), 32'd1);
    tick();
    d_in[0] = mk(OP_JALR, 3'd0, 1'b0, 5'd1, 5'd2, 5'd0); tick();
    d_in[0] = nop;
    #1;
    lit("jalr_flush", 32'(flush_o[0]), 32'd1);
    lit("jalr_jb_op1", 32'(jb_o[0]), 32'd0);
    lit("jalr_alu_op1", 32'(op1_o[0]), 32'd1);
    tick();

    // stores: sb, sh, sw, f3=011
    d_in[0] = mk(OP_ST, 3'd0, 1'b0, 5'd5, 5'd1, 5'd2); tick();
    d_in[0] = mk(OP_ST, 3'd1, 1'b0, 5'd5, 5'd1, 5'd2); tick();
    d_in[0] = mk(OP_ST, 3'd2, 1'b0, 5'd5, 5'd1, 5'd2);
    #1; lit("sb_lanes", 32'(dm_o[0]), 32'h1);
    tick();
    d_in[0] = mk(OP_ST, 3'd3, 1'b0, 5'd5, 5'd1, 5'd2);
    #1; lit("sh_lanes", 32'(dm_o[0]), 32'h3);
    tick();
    d_in[0] = nop;
    #1; lit("sw_lanes", 32'(dm_o[0]), 32'hf);
    tick();
    #1;
    lit("f3_011_lanes", 32'(dm_o[0]), 32'h0);
    lit("store_wb_en", 32'(wb_o[0]), 32'd0);
    tick();

    // no forwarding, no bypass: add x1 then sub x2,x1,x1
    d_in[1] = mk(OP_R, 3'd0, 1'b0, 5'd1, 5'd2, 5'd3); tick();
    d_in[1] = mk(OP_R, 3'd0, 1'b1, 5'd2, 5'd1, 5'd1);
    for (int i = 0; i < 3; i++) begin
      #1; lit("nofwd_stall_on", 32'(stall_o[1]), 32'd1);
      tick();
    end
    #1; lit("nofwd_stall_off", 32'(stall_o[1]), 32'd0);
    tick();
    d_in[1] = nop;
    #1;
    lit("nofwd_rs1_sel", 32'(e1_o[1]), 32'd0);
    lit("nofwd_rs2_sel", 32'(e2_o[1]), 32'd0);
    lit("nofwd_sub_f7", 32'(ef7_o[1]), 32'd1);
    tick();

    // randomized traffic; D is held while the model predicts a stall
    for (int c = 0; c < 3000; c++) begin
      rst_n = ($urandom_range(0, 63) != 0);
      for (int k = 0; k < 2; k++) begin
        if (!last_stall[k]) d_in[k] = rnd_ins();
        b_in[k] = 1'($urandom_range(0, 1));
      end
      tick();
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
